// File: rtl/grayscale_pkg.sv
// Shared opcodes, default weights and weight-set layout for the RGB565 grayscale unit.
package grayscale_pkg;

    typedef enum logic [1:0] {
        OP_CONVERT  = 2'd0,
        OP_WRITE_W  = 2'd1,
        OP_READ_W   = 2'd2,
        OP_RESERVED = 2'd3
    } opcode_e;

    localparam logic [7:0] W_R_DEF = 8'd54;
    localparam logic [7:0] W_G_DEF = 8'd183;
    localparam logic [7:0] W_B_DEF = 8'd19;

    localparam int unsigned LATENCY = 2;

    // Bus layout of a weight set: R in [7:0], G in [15:8], B in [23:16].
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } weight_set_t;

    localparam weight_set_t W_DEF = '{b: W_B_DEF, g: W_G_DEF, r: W_R_DEF};

endpackage

// File: rtl/gray_pixel_mac.sv
// Unpacks one RGB565 pixel to 8-bit channels and forms the three weighted products.
module gray_pixel_mac #(
    parameter int unsigned WEIGHT_BITS = 8
) (
    input  logic [15:0]            pixel,
    input  logic [WEIGHT_BITS-1:0] w_r,
    input  logic [WEIGHT_BITS-1:0] w_g,
    input  logic [WEIGHT_BITS-1:0] w_b,
    output logic [WEIGHT_BITS+7:0] p_r,
    output logic [WEIGHT_BITS+7:0] p_g,
    output logic [WEIGHT_BITS+7:0] p_b
);

    localparam int unsigned PW = WEIGHT_BITS + 8;

    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    always_comb begin
        r   = {pixel[15:11], 3'b000};
        g   = {pixel[10:5],  2'b00};
        b   = {pixel[4:0],   3'b000};
        p_r = PW'(r) * PW'(w_r);
        p_g = PW'(g) * PW'(w_g);
        p_b = PW'(b) * PW'(w_b);
    end

endmodule

// File: rtl/rgb565_grayscale_pipe.sv
// Two-stage pipelined RGB565-to-luma custom instruction with programmable weights.
// Define GRAYSCALE_ROUND_EN for round-to-nearest instead of truncation.
module rgb565_grayscale_pipe
    import grayscale_pkg::*;
#(
    parameter logic [7:0]  CUSTOM_INSTRUCTION_ID = 8'd0,
    parameter int unsigned NR_PIXELS             = 2,
    parameter int unsigned WEIGHT_BITS           = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic        ciDone,
    output logic [31:0] ciResult
);

    localparam int unsigned PW = WEIGHT_BITS + 8;
    localparam int unsigned SW = PW + 2;
    localparam int unsigned QW = SW - 8;
    localparam logic [7:0]  WMASK = 8'((32'd1 << WEIGHT_BITS) - 32'd1);

`ifdef GRAYSCALE_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(128);
`else
    localparam logic [SW-1:0] RND = '0;
`endif

    logic        accept;
    opcode_e     op_in;
    weight_set_t w_q;
    weight_set_t w_new;

    logic [PW-1:0] pr [NR_PIXELS];
    logic [PW-1:0] pg [NR_PIXELS];
    logic [PW-1:0] pb [NR_PIXELS];

    logic          v1_q;
    opcode_e       op1_q;
    weight_set_t   snap1_q;
    logic [PW-1:0] pr1_q [NR_PIXELS];
    logic [PW-1:0] pg1_q [NR_PIXELS];
    logic [PW-1:0] pb1_q [NR_PIXELS];

    logic [SW-1:0] sum;
    logic [QW-1:0] q;
    logic [31:0]   res_c;

    logic unused_bits;
    assign unused_bits = ^{ciValueB[31:2], ciValueA};

    assign accept = ciStart && ciCke && (ciN == CUSTOM_INSTRUCTION_ID);
    assign op_in  = opcode_e'(ciValueB[1:0]);

    always_comb begin
        w_new.r = ciValueA[7:0]   & WMASK;
        w_new.g = ciValueA[15:8]  & WMASK;
        w_new.b = ciValueA[23:16] & WMASK;
    end

    for (genvar k = 0; k < NR_PIXELS; k++) begin : g_mac
        gray_pixel_mac #(
            .WEIGHT_BITS(WEIGHT_BITS)
        ) u_mac (
            .pixel(ciValueA[16*k +: 16]),
            .w_r  (w_q.r[WEIGHT_BITS-1:0]),
            .w_g  (w_q.g[WEIGHT_BITS-1:0]),
            .w_b  (w_q.b[WEIGHT_BITS-1:0]),
            .p_r  (pr[k]),
            .p_g  (pg[k]),
            .p_b  (pb[k])
        );
    end

    // Stage 1: the weight snapshot is taken before a WRITE_W updates w_q,
    // so WRITE_W returns the previous set and READ_W the current one.
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q    <= 1'b0;
            op1_q   <= OP_CONVERT;
            snap1_q <= '0;
            w_q     <= W_DEF;
            for (int unsigned k = 0; k < NR_PIXELS; k++) begin
                pr1_q[k] <= '0;
                pg1_q[k] <= '0;
                pb1_q[k] <= '0;
            end
        end else if (ciCke) begin
            v1_q <= accept;
            if (accept) begin
                op1_q   <= op_in;
                snap1_q <= w_q;
                for (int unsigned k = 0; k < NR_PIXELS; k++) begin
                    pr1_q[k] <= pr[k];
                    pg1_q[k] <= pg[k];
                    pb1_q[k] <= pb[k];
                end
                if (op_in == OP_WRITE_W) begin
                    w_q <= w_new;
                end
            end
        end
    end

    always_comb begin
        res_c = '0;
        sum   = '0;
        q     = '0;
        if (op1_q == OP_CONVERT) begin
            for (int unsigned k = 0; k < NR_PIXELS; k++) begin
                sum = SW'(pr1_q[k]) + SW'(pg1_q[k]) + SW'(pb1_q[k]) + RND;
                q   = sum[SW-1:8];
                res_c[8*k +: 8] = (q > QW'(255)) ? 8'hFF : q[7:0];
            end
        end else begin
            res_c = {8'h00, snap1_q};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ciDone   <= 1'b0;
            ciResult <= '0;
        end else if (ciCke) begin
            ciDone   <= v1_q;
            ciResult <= v1_q ? res_c : '0;
        end
    end

endmodule

// File: tb/tb_rgb565_grayscale_pipe.sv
// Directed self-checking bench for rgb565_grayscale_pipe (2-pixel and 1-pixel builds).
module tb_rgb565_grayscale_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        ciDone1;
    logic [31:0] ciResult1;

    int checks = 0;
    int errors = 0;

    // 0xFFFF: 54*248 + 183*252 + 19*248 = 64220 -> 250 truncated, 251 rounded.
`ifdef GRAYSCALE_ROUND_EN
    localparam logic [7:0] G_WHITE = 8'hFB;
`else
    localparam logic [7:0] G_WHITE = 8'hFA;
`endif
    localparam logic [7:0] G_RED  = 8'h34;  // 13392 -> 52 either way
    localparam logic [7:0] G_BLUE = 8'h12;  // 4712 -> 18 either way

    always #5 clock = ~clock;

    rgb565_grayscale_pipe #(
        .CUSTOM_INSTRUCTION_ID(8'd0),
        .NR_PIXELS(2),
        .WEIGHT_BITS(8)
    ) dut (
        .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke),
        .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciDone(ciDone), .ciResult(ciResult)
    );

    rgb565_grayscale_pipe #(
        .CUSTOM_INSTRUCTION_ID(8'd0),
        .NR_PIXELS(1),
        .WEIGHT_BITS(8)
    ) dut1 (
        .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke),
        .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciDone(ciDone1), .ciResult(ciResult1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a);
        ciStart  = 1'b1;
        ciN      = 8'd0;
        ciValueB = {30'd0, op};
        ciValueA = a;
        tick();
        ciStart  = 1'b0;
        ciValueA = '0;
        ciValueB = '0;
    endtask

    initial begin
        reset = 1'b1; ciStart = 1'b0; ciCke = 1'b1; ciN = '0; ciValueA = '0; ciValueB = '0;
        tick(); tick();
        chk("reset_done", {31'd0, ciDone}, 32'd0);
        chk("reset_result", ciResult, 32'd0);
        reset = 1'b0;
        tick();

        // Two-pixel convert with default weights
        issue(2'd0, 32'hF800FFFF);
        chk("conv_lat1_done", {31'd0, ciDone}, 32'd0);
        tick();
        chk("conv_done", {31'd0, ciDone}, 32'd1);
        chk("conv_result2", ciResult, {16'd0, G_RED, G_WHITE});
        chk("conv_result1", ciResult1, {24'd0, G_WHITE});
        tick();
        chk("conv_done_pulse", {31'd0, ciDone}, 32'd0);
        chk("conv_result_zero", ciResult, 32'd0);

        // Weight write followed immediately by a convert using the new weights
        issue(2'd1, 32'h00FFFFFF);
        issue(2'd0, 32'h0000FFFF);
        chk("write_done", {31'd0, ciDone}, 32'd1);
        chk("write_old_w", ciResult, 32'h0013B736);
        tick();
        chk("conv_sat_done", {31'd0, ciDone}, 32'd1);
        chk("conv_sat", ciResult, 32'h000000FF);
        issue(2'd2, 32'h0);
        tick();
        chk("read_new_w", ciResult, 32'h00FFFFFF);
        issue(2'd1, 32'h0013B736);
        tick();
        chk("restore_old_w", ciResult, 32'h00FFFFFF);
        tick();

        // Foreign ID is ignored, even as a weight write
        ciStart = 1'b1; ciN = 8'd1; ciValueB = 32'd1; ciValueA = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bad_id_done", {31'd0, ciDone}, 32'd0);
            chk("bad_id_result", ciResult, 32'd0);
        end
        ciStart = 1'b0; ciN = 8'd0; ciValueB = '0;
        issue(2'd3, 32'h0);
        tick();
        chk("reserved_read_w", ciResult, 32'h0013B736);
        tick();

        // Three back-to-back converts on the single-pixel build
        issue(2'd0, 32'h0000FFFF);
        issue(2'd0, 32'h0000F800);
        chk("b2b_done0", {31'd0, ciDone1}, 32'd1);
        chk("b2b_res0", ciResult1, {24'd0, G_WHITE});
        issue(2'd0, 32'h0000001F);
        chk("b2b_done1", {31'd0, ciDone1}, 32'd1);
        chk("b2b_res1", ciResult1, {24'd0, G_RED});
        tick();
        chk("b2b_done2", {31'd0, ciDone1}, 32'd1);
        chk("b2b_res2", ciResult1, {24'd0, G_BLUE});
        tick();
        chk("b2b_idle", {31'd0, ciDone1}, 32'd0);

        // Clock enable stalls the pipeline and holds the outputs
        issue(2'd0, 32'h0000FFFF);
        ciCke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_done", {31'd0, ciDone}, 32'd0);
        end
        ciCke = 1'b1;
        tick();
        chk("stall_done", {31'd0, ciDone}, 32'd1);
        chk("stall_result", ciResult, {24'd0, G_WHITE});
        ciCke = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_done", {31'd0, ciDone}, 32'd1);
            chk("hold_result", ciResult, {24'd0, G_WHITE});
        end
        ciCke = 1'b1;
        tick();
        chk("release_done", {31'd0, ciDone}, 32'd0);

        // Reset one cycle after accept drops the instruction and restores weights
        issue(2'd1, 32'h00FFFFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_no_done", {31'd0, ciDone}, 32'd0);
            tick();
        end
        issue(2'd2, 32'h0);
        tick();
        chk("post_reset_w_done", {31'd0, ciDone}, 32'd1);
        chk("post_reset_w", ciResult, 32'h0013B736);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
